// File: rtl/tdm_demux_1x4.sv
// Receive-side 1:4 TDM demultiplexer: recovers slot alignment from a frame-sync marker,
// fans words out to per-channel holding registers and publishes whole frames atomically.
module tdm_demux_1x4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [WIDTH-1:0]   ch0,
  output logic [WIDTH-1:0]   ch1,
  output logic [WIDTH-1:0]   ch2,
  output logic [WIDTH-1:0]   ch3,
  output logic [3:0]         ch_valid,
  output logic [4*WIDTH-1:0] frame_out,
  output logic               frame_done,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic               accept;
  logic [1:0]         wr_slot;
  logic               err;
  logic [WIDTH-1:0]   ch_q [4];
  logic [3:0]         ch_valid_q;
  logic [4*WIDTH-1:0] frame_out_q;
  logic               frame_done_q;
  logic               sync_err_q;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    accept  = 1'b0;
    wr_slot = 2'd0;
    err     = 1'b0;
    case (state_q)
      StHunt: begin
        if (din_valid && frame_sync) begin
          accept  = 1'b1;
          slot_d  = 2'd1;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (din_valid) begin
          if (frame_sync) begin
            // A marker mid-frame realigns to slot 0 and abandons the partial frame.
            accept = 1'b1;
            slot_d = 2'd1;
            err    = (slot_q != 2'd0);
          end else if (slot_q == 2'd0) begin
            err     = 1'b1;
            slot_d  = 2'd0;
            state_d = StHunt;
          end else begin
            accept  = 1'b1;
            wr_slot = slot_q;
            slot_d  = slot_q + 2'd1;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // The channel registers double as the frame-assembly buffer: slots 0..2 of the current
  // frame are always rewritten before slot 3 completes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      slot_q       <= 2'd0;
      ch_valid_q   <= 4'b0000;
      frame_out_q  <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) ch_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      ch_valid_q   <= accept ? (4'b0001 << wr_slot) : 4'b0000;
      frame_done_q <= accept && (wr_slot == 2'd3);
      sync_err_q   <= err;
      if (accept) ch_q[wr_slot] <= din;
      if (accept && (wr_slot == 2'd3)) frame_out_q <= {din, ch_q[2], ch_q[1], ch_q[0]};
    end
  end

  assign ch0        = ch_q[0];
  assign ch1        = ch_q[1];
  assign ch2        = ch_q[2];
  assign ch3        = ch_q[3];
  assign ch_valid   = ch_valid_q;
  assign frame_out  = frame_out_q;
  assign frame_done = frame_done_q;
  assign locked     = (state_q == StLocked);
  assign sync_err   = sync_err_q;

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive-side counterpart of the 4:1 channel mux: splits one time-division-multiplexed word stream back into 4 channel outputs.
- The slot counter is recovered from a frame-sync marker. Each word goes to a per-channel holding register.
- A complete frame is also double-buffered onto a wide output bus, which updates atomically once per frame.
- Sits between the serial link and the per-channel consumers.

Parameters:
- WIDTH, 8, data word width per channel (legal range 1 to 32).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  multiplexed data word.
- din_valid  input  1  din carries a word this cycle.
- frame_sync  input  1  qualified by din_valid; marks the current word as slot 0.
- ch0, ch1, ch2, ch3  output  WIDTH each  per-channel holding registers.
- ch_valid  output  4  one-cycle strobe; bit k set when chk was written.
- frame_out  output  4*WIDTH  last complete frame: {ch3,ch2,ch1,ch0}, ch0 in LSBs.
- frame_done  output  1  one-cycle strobe when frame_out updates.
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle strobe on misaligned frame_sync.

Behaviour:
- Reset (async assert, sync-safe release): all outputs 0, state HUNT, slot counter 0, internal frame-assembly buffer 0.
- States:
  - HUNT: words without frame_sync are dropped; no register or strobe changes.
  - LOCKED: words are accepted into slots.
- A beat is a cycle with din_valid=1. frame_sync with din_valid=0 is ignored.
- HUNT to LOCKED: a beat with frame_sync=1.
  - That word is slot 0.
  - ch0 is written and ch_valid[0] pulses next cycle.
  - Slot counter goes to 1.
- LOCKED, beat with frame_sync=0:
  - The word is written to ch[slot] and ch_valid[slot] pulses.
  - Slot increments modulo 4 (3 wraps to 0).
- LOCKED, beat with frame_sync=1 and slot==0: normal slot-0 write; no error.
- LOCKED, beat with frame_sync=1 and slot!=0 (misalignment):
  - sync_err pulses.
  - The word is realigned as slot 0: ch0 is written and ch_valid[0] pulses. Slot goes to 1.
  - The partial frame is discarded; frame_done does not pulse.
  - State stays LOCKED.
- LOCKED, beat with slot==0 and frame_sync=0 (sync marker missing at frame boundary):
  - sync_err pulses.
  - State goes to HUNT, slot goes to 0.
  - The word is dropped.
- Frame assembly:
  - Each accepted word is also written into the internal assembly buffer at its slot.
  - On the slot-3 write, frame_out is loaded with the three buffered words plus the slot-3 word, and frame_done pulses.
  - frame_out holds its value between frames and is never partially updated.
- Latency: exactly 1 cycle from the accepting clk edge to the register or strobe being visible, for ch*, ch_valid, frame_out, frame_done and sync_err.
- din_valid=0 cycles inside a frame:
  - Slot and state hold.
  - All strobes are 0; data registers hold.
- Strobes are at most one cycle wide. At most one ch_valid bit is set per cycle.
- locked reflects the registered state. It is 1 from the cycle after the locking beat.
- Reset asserted mid-frame: everything returns to reset values immediately, and the partial frame is lost.
- No backpressure: consumers must sample on the strobes.

Test Plan:
- Reset then lock (WIDTH=8): 8 beats 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with frame_sync on beats 1 and 5 -> ch0..ch3 = 0x55,0x66,0x77,0x88 at the end. frame_done pulses twice; frame_out = 0x88776655 at the end. sync_err is never set.
- Pre-lock garbage: 3 beats 0xAA with no frame_sync, then a synced frame 0x01..0x04 -> all outputs stay 0 until the sync beat. locked rises the cycle after it. frame_out = 0x04030201.
- Gaps: frame 0x10,0x20,0x30,0x40 with din_valid low for 2 cycles between every beat -> same result as back-to-back. Each ch_valid bit pulses exactly once. frame_done pulses once, one cycle after the 0x40 beat.
- Misaligned sync: frame 0x01..0x04, then 0x05,0x06, then a frame_sync beat 0x09 followed by 0x0A,0x0B,0x0C -> sync_err pulses once. frame_out goes to 0x04030201 then 0x0C0B0A09, and is never 0x....0605. locked stays 1.
- Lost sync: after a full frame, a slot-0 beat with frame_sync=0 -> sync_err pulses, locked drops, ch0 is unchanged. Later beats are ignored until frame_sync.
- Async reset mid-frame: assert rst_n low between clock edges after 2 beats -> all outputs 0 immediately without waiting for a clk edge. After release, locked stays 0 until a new frame_sync beat.
